// File: rtl/n64adv2_i2s_tx_pkg.sv
// Shared audio configuration for the I2S transmitter: frame geometry, FSM and word-slot types.
package n64adv2_i2s_tx_pkg;

  localparam int FRAME_LEN = 256;
  localparam int SLOT_W    = 32;
  localparam int SMPL_W    = 16;
  localparam int SCLK_DIV  = 4;

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam int BIT_W = CNT_W - DIV_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    WS_NONE  = 2'd0,
    WS_LEFT  = 2'd1,
    WS_RIGHT = 2'd2
  } word_e;

  // One-bit I2S delay: each word starts one bit after its LRCLK edge.
  function automatic word_e word_sel(input logic [BIT_W-1:0] b);
    word_e sel;
    sel = WS_NONE;
    if (b >= BIT_W'(1) && b <= BIT_W'(SMPL_W)) begin
      sel = WS_LEFT;
    end else if (b >= BIT_W'(SLOT_W + 1) && b <= BIT_W'(SLOT_W + SMPL_W)) begin
      sel = WS_RIGHT;
    end
    return sel;
  endfunction

endpackage

// File: rtl/n64adv2_i2s_tx_if.sv
// Sample-pair handshake between the audio processing path and the I2S transmitter.
interface n64adv2_i2s_tx_if;
  import n64adv2_i2s_tx_pkg::*;

  logic [SMPL_W-1:0] SMPL_L_i;
  logic [SMPL_W-1:0] SMPL_R_i;
  logic              SMPL_valid_i;
  logic              SMPL_ready_o;

  modport master (
    output SMPL_L_i,
    output SMPL_R_i,
    output SMPL_valid_i,
    input  SMPL_ready_o
  );

  modport slave (
    input  SMPL_L_i,
    input  SMPL_R_i,
    input  SMPL_valid_i,
    output SMPL_ready_o
  );

endinterface

// File: rtl/n64adv2_i2s_tx.sv
// I2S transmitter: 256-cycle MCLK frame, single-entry sample buffer, per-frame word load.
// state   | meaning
// ST_IDLE | disabled, counter parked at 0, outputs low
// ST_RUN  | frame counter running, words shifted out
module n64adv2_i2s_tx
  import n64adv2_i2s_tx_pkg::*;
(
  input  logic            MCLK_i,
  input  logic            nRST_i,
  input  logic            en_i,
  input  logic            mute_i,
  n64adv2_i2s_tx_if.slave smpl_if,
  output logic            SCLK_o,
  output logic            LRCLK_o,
  output logic            SDATA_o,
  output logic            UNDERRUN_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic [SMPL_W-1:0] buf_l_q, buf_l_d;
  logic [SMPL_W-1:0] buf_r_q, buf_r_d;
  logic [SMPL_W-1:0] sh_l_q, sh_l_d;
  logic [SMPL_W-1:0] sh_r_q, sh_r_d;
  logic              ready_q, ready_d;
  logic              sclk_q, sclk_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic              undr_q, undr_d;

  logic              run_d;
  logic              load;
  logic              xfer;
  logic [BIT_W-1:0]  bit_d;
  word_e             sel_d;

  always_ff @(posedge MCLK_i or negedge nRST_i) begin
    if (!nRST_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      buf_l_q <= '0;
      buf_r_q <= '0;
      sh_l_q  <= '0;
      sh_r_q  <= '0;
      ready_q <= 1'b1;
      sclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      undr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      buf_l_q <= buf_l_d;
      buf_r_q <= buf_r_d;
      sh_l_q  <= sh_l_d;
      sh_r_q  <= sh_r_d;
      ready_q <= ready_d;
      sclk_q  <= sclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      undr_q  <= undr_d;
    end
  end

  // Outputs are registered from the next counter value so they line up with cnt_q.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_IDLE: if (en_i) state_d = ST_RUN;
      ST_RUN:  if (!en_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    run_d = (state_d == ST_RUN);
    if (state_q == ST_RUN && run_d) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    bit_d = cnt_d[CNT_W-1:DIV_W];
    sel_d = word_sel(bit_d);
    load  = run_d && (cnt_d == '0);
    xfer  = smpl_if.SMPL_valid_i && !full_q;
  end

  // A load on a full buffer wins: ready was already low, so no transfer can collide with it.
  always_comb begin
    buf_l_d = buf_l_q;
    buf_r_d = buf_r_q;
    full_d  = full_q;
    if (xfer) begin
      buf_l_d = smpl_if.SMPL_L_i;
      buf_r_d = smpl_if.SMPL_R_i;
    end
    if (load) begin
      full_d = xfer;
    end else if (xfer) begin
      full_d = 1'b1;
    end
    ready_d = !full_d;
  end

  always_comb begin
    sh_l_d  = sh_l_q;
    sh_r_d  = sh_r_q;
    sdata_d = sdata_q;
    undr_d  = 1'b0;
    sclk_d  = run_d && cnt_d[DIV_W-1];
    lrclk_d = run_d && cnt_d[CNT_W-1];

    if (!run_d) begin
      sh_l_d  = '0;
      sh_r_d  = '0;
      sdata_d = 1'b0;
    end else if (load) begin
      sdata_d = 1'b0;
      undr_d  = !full_q && !mute_i;
      if (full_q && !mute_i) begin
        sh_l_d = buf_l_q;
        sh_r_d = buf_r_q;
      end else begin
        sh_l_d = '0;
        sh_r_d = '0;
      end
    end else if (cnt_d[DIV_W-1:0] == '0) begin
      unique case (sel_d)
        WS_LEFT: begin
          sdata_d = sh_l_q[SMPL_W-1];
          sh_l_d  = {sh_l_q[SMPL_W-2:0], 1'b0};
        end
        WS_RIGHT: begin
          sdata_d = sh_r_q[SMPL_W-1];
          sh_r_d  = {sh_r_q[SMPL_W-2:0], 1'b0};
        end
        default: sdata_d = 1'b0;
      endcase
    end
  end

  assign smpl_if.SMPL_ready_o = ready_q;
  assign SCLK_o               = sclk_q;
  assign LRCLK_o              = lrclk_q;
  assign SDATA_o              = sdata_q;
  assign UNDERRUN_o           = undr_q;

endmodule

// File: tb/tb_n64adv2_i2s_tx.sv
// Directed bench for the I2S transmitter: frame contents, underrun, load/push collision, mute, reset, enable.
module tb_n64adv2_i2s_tx;
  import n64adv2_i2s_tx_pkg::*;

  logic MCLK_i = 1'b0;
  logic nRST_i;
  logic en_i;
  logic mute_i;
  logic SCLK_o, LRCLK_o, SDATA_o, UNDERRUN_o;

  int checks = 0;
  int errors = 0;
  int pos = 0;

  n64adv2_i2s_tx_if smpl_if ();

  n64adv2_i2s_tx dut (
    .MCLK_i    (MCLK_i),
    .nRST_i    (nRST_i),
    .en_i      (en_i),
    .mute_i    (mute_i),
    .smpl_if   (smpl_if),
    .SCLK_o    (SCLK_o),
    .LRCLK_o   (LRCLK_o),
    .SDATA_o   (SDATA_o),
    .UNDERRUN_o(UNDERRUN_o)
  );

  always #5 MCLK_i = ~MCLK_i;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge MCLK_i);
    #1;
    pos = (pos + 1) % 256;
  endtask

  task automatic start();
    en_i = 1'b1;
    @(posedge MCLK_i);
    #1;
    pos = 0;
  endtask

  task automatic advance_to(input int target);
    while (pos != target) step();
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int n;
    n = 0;
    while (!smpl_if.SMPL_ready_o && n < 600) begin
      step();
      n++;
    end
    check_val("push_wait_ok", int'(n < 600), 1);
    smpl_if.SMPL_L_i     = l;
    smpl_if.SMPL_R_i     = r;
    smpl_if.SMPL_valid_i = 1'b1;
    step();
    smpl_if.SMPL_valid_i = 1'b0;
  endtask

  // Runs from the current frame position up to the next frame start, comparing every cycle.
  task automatic run_frame(input logic [15:0] el, input logic [15:0] er, input bit glitch,
                           output int e_data, output int e_clk, output int n_undr,
                           output int undr_pos);
    int   b;
    logic exp_sd;
    e_data   = 0;
    e_clk    = 0;
    n_undr   = 0;
    undr_pos = -1;
    do begin
      b      = pos / 4;
      exp_sd = 1'b0;
      if (b >= 1 && b <= 16) exp_sd = el[16-b];
      else if (b >= 33 && b <= 48) exp_sd = er[48-b];
      if (SDATA_o !== exp_sd) e_data++;
      if (SCLK_o !== ((pos % 4) >= 2)) e_clk++;
      if (LRCLK_o !== (pos >= 128)) e_clk++;
      if (UNDERRUN_o === 1'b1) begin
        n_undr++;
        if (undr_pos < 0) undr_pos = pos;
      end
      if (glitch) mute_i = (pos >= 8 && pos < 40);
      step();
    end while (pos != 0);
    mute_i = 1'b0;
  endtask

  initial begin
    int ed, ec, nu, up, hi;
    nRST_i = 1'b0;
    en_i   = 1'b0;
    mute_i = 1'b0;
    smpl_if.SMPL_L_i     = '0;
    smpl_if.SMPL_R_i     = '0;
    smpl_if.SMPL_valid_i = 1'b0;
    repeat (3) step();
    check_val("rst_ready", smpl_if.SMPL_ready_o, 1);
    check_val("rst_sclk", SCLK_o, 0);
    check_val("rst_lrclk", LRCLK_o, 0);
    check_val("rst_sdata", SDATA_o, 0);
    check_val("rst_undr", UNDERRUN_o, 0);
    nRST_i = 1'b1;
    repeat (2) step();

    // Frame with A5C3 / 0F01, buffered while still disabled.
    push(16'hA5C3, 16'h0F01);
    check_val("dis_accept_full", smpl_if.SMPL_ready_o, 0);
    start();
    check_val("f1_ready0", smpl_if.SMPL_ready_o, 1);
    run_frame(16'hA5C3, 16'h0F01, 1'b0, ed, ec, nu, up);
    check_val("f1_data", ed, 0);
    check_val("f1_clk", ec, 0);
    check_val("f1_undr", nu, 0);

    // Nothing pushed: underrun at frame start, all-zero data.
    run_frame(16'h0000, 16'h0000, 1'b0, ed, ec, nu, up);
    check_val("f2_data", ed, 0);
    check_val("f2_undr_cnt", nu, 1);
    check_val("f2_undr_pos", up, 0);

    // Push offered on the load cycle while the buffer is still full.
    push(16'h1234, 16'h8001);
    advance_to(255);
    smpl_if.SMPL_L_i     = 16'hCAFE;
    smpl_if.SMPL_R_i     = 16'h0055;
    smpl_if.SMPL_valid_i = 1'b1;
    check_val("coin_ready_lo", smpl_if.SMPL_ready_o, 0);
    step();
    check_val("coin_ready_hi", smpl_if.SMPL_ready_o, 1);
    check_val("coin_undr", UNDERRUN_o, 0);
    step();
    smpl_if.SMPL_valid_i = 1'b0;
    check_val("coin_accepted", smpl_if.SMPL_ready_o, 0);
    run_frame(16'h1234, 16'h8001, 1'b0, ed, ec, nu, up);
    check_val("f3_data", ed, 0);
    run_frame(16'hCAFE, 16'h0055, 1'b0, ed, ec, nu, up);
    check_val("f4_data", ed, 0);
    check_val("f4_undr", nu, 0);
    run_frame(16'h0000, 16'h0000, 1'b0, ed, ec, nu, up);
    check_val("f5_no_dup_data", ed, 0);
    check_val("f5_no_dup_undr", nu, 1);

    // Mute at load with 7FFF buffered: zeros, buffer consumed, no underrun.
    push(16'h7FFF, 16'h7FFF);
    advance_to(255);
    mute_i = 1'b1;
    step();
    mute_i = 1'b0;
    check_val("mute_undr", UNDERRUN_o, 0);
    check_val("mute_ready", smpl_if.SMPL_ready_o, 1);
    push(16'h1357, 16'h2468);
    run_frame(16'h0000, 16'h0000, 1'b0, ed, ec, nu, up);
    check_val("f6_mute_data", ed, 0);
    check_val("f6_mute_undr", nu, 0);

    // Mid-frame mute pulse and buffer refill must not touch the word in flight.
    push(16'hFFFF, 16'h2222);
    run_frame(16'h1357, 16'h2468, 1'b1, ed, ec, nu, up);
    check_val("f7_glitch_data", ed, 0);
    check_val("f7_glitch_undr", nu, 0);

    // Reset at b=10 with a full buffer and the left word on the line.
    push(16'h0F0F, 16'hF0F0);
    advance_to(42);
    check_val("pre_rst_sclk", SCLK_o, 1);
    check_val("pre_rst_sdata", SDATA_o, 1);
    nRST_i = 1'b0;
    #1;
    check_val("mid_rst_sclk", SCLK_o, 0);
    check_val("mid_rst_lrclk", LRCLK_o, 0);
    check_val("mid_rst_sdata", SDATA_o, 0);
    check_val("mid_rst_undr", UNDERRUN_o, 0);
    check_val("mid_rst_ready", smpl_if.SMPL_ready_o, 1);
    repeat (3) step();
    nRST_i = 1'b1;
    step();
    pos = 0;
    run_frame(16'h0000, 16'h0000, 1'b0, ed, ec, nu, up);
    check_val("post_rst_data", ed, 0);
    check_val("post_rst_clk", ec, 0);
    check_val("post_rst_undr_pos", up, 0);

    // Disabled for 1000 cycles, then a fresh frame one cycle after enable.
    en_i = 1'b0;
    hi = 0;
    repeat (1000) begin
      step();
      if (SCLK_o !== 1'b0 || LRCLK_o !== 1'b0 || SDATA_o !== 1'b0 || UNDERRUN_o !== 1'b0) hi++;
    end
    check_val("dis_outputs_low", hi, 0);
    push(16'hABCD, 16'h1234);
    check_val("dis_buf_full", smpl_if.SMPL_ready_o, 0);
    start();
    check_val("en_ready0", smpl_if.SMPL_ready_o, 1);
    check_val("en_undr0", UNDERRUN_o, 0);
    run_frame(16'hABCD, 16'h1234, 1'b0, ed, ec, nu, up);
    check_val("en_data", ed, 0);
    check_val("en_clk", ec, 0);
    check_val("en_undr", nu, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
